// File: rtl/vga_write_arbiter_pkg.sv
// Shared types and defaults for the VGA plot-port arbiter.
// Defaults size a four-client arbiter driving a 10-bit-coordinate, 3-bit-colour adapter.
package vga_write_arbiter_pkg;

    localparam int DEF_NUM_CLIENTS = 4;
    localparam int DEF_TIMEOUT     = 1023;
    localparam int DEF_XY_W        = 10;
    localparam int DEF_COL_W       = 3;

    localparam logic [DEF_COL_W-1:0] BLACK = '0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OWN,
        ST_RELEASE
    } arb_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vga_write_arbiter_rr_picker.sv
// Combinational round-robin select: first requester at or after start, wrapping.
// Zero latency; produces an all-zero pick when nothing requests.
module vga_write_arbiter_rr_picker #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] start,
    output logic [N-1:0]     pick,
    output logic [IDX_W-1:0] pick_idx
);

    int idx;

    // Walk from lowest to highest priority so the highest-priority hit is written last.
    always_comb begin
        pick     = '0;
        pick_idx = '0;
        idx      = 0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = (int'(start) + i) % N;
            if (req[idx]) begin
                pick      = '0;
                pick[idx] = 1'b1;
                pick_idx  = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/vga_write_arbiter.sv
// Grants the single VGA plot port to one client at a time via req/grant/done, with a watchdog.
// Pixel strobe to writeEn is one cycle; foreign strobes are dropped, owners are never stalled.
module vga_write_arbiter
    import vga_write_arbiter_pkg::*;
#(
    parameter int NUM_CLIENTS = DEF_NUM_CLIENTS,
    parameter int TIMEOUT     = DEF_TIMEOUT,
    parameter int XY_W        = DEF_XY_W,
    parameter int COL_W       = DEF_COL_W
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [NUM_CLIENTS-1:0]   req,
    input  logic [NUM_CLIENTS-1:0]   done,
    input  logic [NUM_CLIENTS-1:0]   erase,
    input  logic [NUM_CLIENTS-1:0]   pix_we,
    input  logic [NUM_CLIENTS*XY_W-1:0]  pix_x,
    input  logic [NUM_CLIENTS*XY_W-1:0]  pix_y,
    input  logic [NUM_CLIENTS*COL_W-1:0] pix_colour,
    output logic [NUM_CLIENTS-1:0]   grant,
    output logic                     busy,
    output logic [XY_W-1:0]          x,
    output logic [XY_W-1:0]          y,
    output logic [COL_W-1:0]         colour,
    output logic                     writeEn,
    output logic                     timeout
);

    localparam int IDX_W = idx_width(NUM_CLIENTS);
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    arb_state_t             state;
    logic [IDX_W-1:0]       owner;
    logic [IDX_W-1:0]       rr_ptr;
    logic [WD_W-1:0]        wdog;
    logic [NUM_CLIENTS-1:0] pick;
    logic [IDX_W-1:0]       pick_idx;

    logic             sel_we, sel_done, sel_req, sel_erase;
    logic [XY_W-1:0]  sel_x, sel_y;
    logic [COL_W-1:0] sel_col;
    logic             wd_hit;

    vga_write_arbiter_rr_picker #(
        .N     (NUM_CLIENTS),
        .IDX_W (IDX_W)
    ) u_rr_picker (
        .req      (req),
        .start    (rr_ptr),
        .pick     (pick),
        .pick_idx (pick_idx)
    );

    always_comb begin
        sel_we    = 1'b0;
        sel_done  = 1'b0;
        sel_req   = 1'b0;
        sel_erase = 1'b0;
        sel_x     = '0;
        sel_y     = '0;
        sel_col   = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (owner == IDX_W'(i)) begin
                sel_we    = pix_we[i];
                sel_done  = done[i];
                sel_req   = req[i];
                sel_erase = erase[i];
                sel_x     = pix_x[i*XY_W +: XY_W];
                sel_y     = pix_y[i*XY_W +: XY_W];
                sel_col   = pix_colour[i*COL_W +: COL_W];
            end
        end
    end

    assign wd_hit = (wdog == WD_W'(TIMEOUT));
    assign busy   = (state != ST_IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= ST_IDLE;
            grant   <= '0;
            owner   <= '0;
            rr_ptr  <= '0;
            wdog    <= '0;
            x       <= '0;
            y       <= '0;
            colour  <= '0;
            writeEn <= 1'b0;
            timeout <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    writeEn <= 1'b0;
                    timeout <= 1'b0;
                    if (|req) begin
                        grant <= pick;
                        owner <= pick_idx;
                        wdog  <= '0;
                        state <= ST_OWN;
                    end
                end
                ST_OWN: begin
                    writeEn <= sel_we;
                    if (sel_we) begin
                        x      <= sel_x;
                        y      <= sel_y;
                        colour <= sel_erase ? COL_W'(BLACK) : sel_col;
                    end
                    wdog <= sel_we ? '0 : wdog + 1'b1;
                    // A clean done/release takes precedence over reporting a watchdog revoke.
                    if (sel_done || !sel_req || wd_hit) begin
                        state   <= ST_RELEASE;
                        grant   <= '0;
                        rr_ptr  <= (owner == IDX_W'(NUM_CLIENTS - 1)) ? '0 : owner + 1'b1;
                        timeout <= wd_hit && !sel_done && sel_req;
                    end
                end
                ST_RELEASE: begin
                    writeEn <= 1'b0;
                    timeout <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_write_arbiter.sv
// Directed bench for the VGA plot-port arbiter: handshake, round-robin order, erase, watchdog, foreign writes, async reset.
module tb_vga_write_arbiter;

    localparam int N  = 4;
    localparam int XW = 10;
    localparam int CW = 3;

    logic             clk;
    logic             resetn;
    logic [N-1:0]     req, done, erase, pix_we;
    logic [N*XW-1:0]  pix_x, pix_y;
    logic [N*CW-1:0]  pix_colour;
    logic [N-1:0]     grant;
    logic             busy;
    logic [XW-1:0]    x, y;
    logic [CW-1:0]    colour;
    logic             writeEn;
    logic             timeout;

    int n_cmp = 0;
    int n_err = 0;

    vga_write_arbiter #(
        .NUM_CLIENTS (N),
        .TIMEOUT     (8),
        .XY_W        (XW),
        .COL_W       (CW)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req        (req),
        .done       (done),
        .erase      (erase),
        .pix_we     (pix_we),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_colour (pix_colour),
        .grant      (grant),
        .busy       (busy),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .writeEn    (writeEn),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pix(input int c, input int xx, input int yy, input int cc);
        pix_x[c*XW +: XW]      = XW'(xx);
        pix_y[c*XW +: XW]      = XW'(yy);
        pix_colour[c*CW +: CW] = CW'(cc);
    endtask

    task automatic wait_grant(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (grant == '0 && n < 40);
        if (grant == '0) check("grant_wait_expired", 32'd1, 32'd0);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    int n;
    int order [5] = '{0, 1, 2, 3, 0};

    initial begin
        resetn = 1'b0;
        req = '0; done = '0; erase = '0; pix_we = '0;
        pix_x = '0; pix_y = '0; pix_colour = '0;
        tick();
        tick();
        check("rst_grant",   32'(grant),   32'd0);
        check("rst_busy",    32'(busy),    32'd0);
        check("rst_writeEn", 32'(writeEn), 32'd0);
        check("rst_x",       32'(x),       32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        resetn = 1'b1;

        // Single client handshake.
        req = 4'b0010;
        tick();
        check("t1_grant", 32'(grant), 32'b0010);
        check("t1_busy",  32'(busy),  32'd1);
        pix_we = 4'b0010;
        set_pix(1, 5, 7, 5);
        tick();
        check("t1_we",  32'(writeEn), 32'd1);
        check("t1_x",   32'(x),       32'd5);
        check("t1_y",   32'(y),       32'd7);
        check("t1_col", 32'(colour),  32'd5);
        pix_we = '0;
        done   = 4'b0010;
        tick();
        check("t1_rel_grant", 32'(grant),   32'd0);
        check("t1_rel_we",    32'(writeEn), 32'd0);
        check("t1_rel_busy",  32'(busy),    32'd1);
        done = '0;
        req  = '0;
        tick();
        check("t1_idle_busy", 32'(busy), 32'd0);

        // Contention: round-robin order from a fresh pointer, RELEASE+IDLE gap between owners.
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_grant(n);
            if (k > 0) check("t2_gap", 32'(n), 32'd2);
            check("t2_grant", 32'(grant), 32'(1) << order[k]);
            pix_we = '0;
            pix_we[order[k]] = 1'b1;
            set_pix(order[k], 10 * order[k] + 1, 10 * order[k] + 2, order[k] + 1);
            tick();
            check("t2_we", 32'(writeEn), 32'd1);
            check("t2_x",  32'(x), 32'(10 * order[k] + 1));
            pix_we = '0;
            done   = '0;
            done[order[k]] = 1'b1;
            tick();
            check("t2_rel_grant", 32'(grant), 32'd0);
            done = '0;
        end

        // Erase forces black for granted client 2.
        req = 4'b0100;
        wait_grant(n);
        check("t3_grant", 32'(grant), 32'b0100);
        pix_we = 4'b0100;
        erase  = 4'b0100;
        set_pix(2, 33, 44, 7);
        tick();
        check("t3_we",  32'(writeEn), 32'd1);
        check("t3_x",   32'(x),       32'd33);
        check("t3_col", 32'(colour),  32'd0);
        pix_we = '0;
        erase  = '0;
        req    = '0;
        tick();
        check("t3_rel_grant", 32'(grant), 32'd0);
        tick();

        // Foreign writes from a non-granted client are ignored.
        req = 4'b0001;
        wait_grant(n);
        check("t5_grant", 32'(grant), 32'b0001);
        pix_we = 4'b0001;
        set_pix(0, 12, 13, 2);
        tick();
        check("t5_own_we", 32'(writeEn), 32'd1);
        check("t5_own_x",  32'(x),       32'd12);
        pix_we = 4'b1000;
        set_pix(3, 99, 99, 6);
        tick();
        check("t5_foreign_we", 32'(writeEn), 32'd0);
        check("t5_foreign_x",  32'(x),       32'd12);
        check("t5_foreign_y",  32'(y),       32'd13);
        pix_we = '0;
        done   = 4'b0001;
        tick();
        done = '0;

        // Watchdog: client 3 holds req but never strobes; revoked after 9 idle OWN cycles.
        req = 4'b1001;
        wait_grant(n);
        check("t4_grant", 32'(grant), 32'b1000);
        repeat (8) tick();
        check("t4_hold_grant",   32'(grant),   32'b1000);
        check("t4_hold_timeout", 32'(timeout), 32'd0);
        tick();
        check("t4_timeout", 32'(timeout), 32'd1);
        check("t4_revoked", 32'(grant),   32'd0);
        tick();
        check("t4_pulse_end", 32'(timeout), 32'd0);
        wait_grant(n);
        check("t4_next", 32'(grant), 32'b0001);

        // Asynchronous reset mid-burst, then fresh round-robin start.
        req    = 4'b1111;
        pix_we = 4'b0001;
        tick();
        check("t6_we_before", 32'(writeEn), 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        check("t6_we_async",    32'(writeEn), 32'd0);
        check("t6_grant_async", 32'(grant),   32'd0);
        check("t6_busy_async",  32'(busy),    32'd0);
        pix_we = '0;
        tick();
        resetn = 1'b1;
        wait_grant(n);
        check("t6_first_grant", 32'(grant), 32'b0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
